d20_roll_loader: RTL and testbench

D20_ROLL_LOADER -- requirements
Module: d20_roll_loader

---
 rtl/d20_pkg.sv | 30 +++
 rtl/d20_lfsr.sv | 41 ++++
 rtl/d20_roll_loader.sv | 140 ++++++++++++++
 tb/tb_d20_roll_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/d20_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : d20_pkg
//  Purpose  : Shared types and constants for the d20 roll loader: FSM state
//             encoding, LFSR feedback mask, die size and default seed, plus
//             the single-step Galois LFSR function.
//  Revision : 1.0 - initial release
// ============================================================================
package d20_pkg;

   // Loader FSM states, explicitly encoded on two bits
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GEN   = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } d20_state_t;

   // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
   localparam logic [15:0] c_LFSR_MASK    = 16'hB400;
   localparam int          c_D20_SIDES    = 20;
   localparam logic [15:0] c_SEED_DEFAULT = 16'hACE1;

   // One Galois step: shift right, fold the mask in when a one falls out
   function automatic logic [15:0] lfsr_advance(input logic [15:0] state);
      lfsr_advance = state[0] ? ((state >> 1) ^ c_LFSR_MASK) : (state >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/d20_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : d20_lfsr
//  Purpose  : 16-bit Galois LFSR with synchronous load and step. A zero load
//             value is replaced by SEED_DEFAULT so the register can never
//             lock up in the all-zero state. Exposes the low five bits of the
//             value the register would take on its next step.
//  Revision : 1.0 - initial release
// ============================================================================
module d20_lfsr
   import d20_pkg::*;
#(
   parameter logic [15:0] SEED_DEFAULT = c_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        step,
   output logic [4:0]  next_bits
);

   logic [15:0] r_state;
   logic [15:0] w_next;

   assign w_next    = lfsr_advance(r_state);
   assign next_bits = w_next[4:0];

   // State register: load wins over step; zero seed falls back to the default
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= SEED_DEFAULT;
      end else if (load) begin
         r_state <= (load_value == 16'd0) ? SEED_DEFAULT : load_value;
      end else if (step) begin
         r_state <= w_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/d20_roll_loader.sv
`default_nettype none
// ============================================================================
//  Module   : d20_roll_loader
//  Purpose  : Fills DEPTH consecutive memory words with uniform d20 rolls
//             (1..20). Each entry is drawn by rejection sampling the low five
//             bits of a Galois LFSR, then written with a write/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module d20_roll_loader
   import d20_pkg::*;
#(
   parameter int          DEPTH        = 32,
   parameter logic [15:0] SEED_DEFAULT = c_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        seed_load,
   input  logic [15:0] seed,
   input  logic        ready,
   output logic        write,
   output logic [31:0] addr,
   output logic [4:0]  data,
   output logic        busy,
   output logic        done
);

   localparam int                 c_CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEPTH - 1);

   d20_state_t         r_state;
   d20_state_t         w_state_next;
   logic [c_CNT_W-1:0] r_count;
   logic [4:0]         r_data;
   logic [4:0]         w_cand;
   logic               w_accept;
   logic               w_last;
   logic               w_lfsr_load;
   logic               w_lfsr_step;

   // Seed only lands while idle; the generator advances only in GEN
   assign w_lfsr_load = (r_state == ST_IDLE) && seed_load;
   assign w_lfsr_step = (r_state == ST_GEN);
   assign w_accept    = (w_cand < 5'(c_D20_SIDES));
   assign w_last      = (r_count == c_LAST);

   d20_lfsr #(
      .SEED_DEFAULT (SEED_DEFAULT)
   ) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .load       (w_lfsr_load),
      .load_value (seed),
      .step       (w_lfsr_step),
      .next_bits  (w_cand)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: seed_load beats start in IDLE, rejects loop in GEN
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (!seed_load && start) begin
               w_state_next = ST_GEN;
            end
         end
         ST_GEN: begin
            if (w_accept) begin
               w_state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (ready) begin
               w_state_next = w_last ? ST_DONE : ST_GEN;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      write = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      unique case (r_state)
         ST_GEN: begin
            busy = 1'b1;
         end
         ST_WRITE: begin
            write = 1'b1;
            busy  = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            write = 1'b0;
         end
      endcase
   end

   // Entry counter and roll latch; the counter holds at DEPTH-1 on the last
   // beat so addr never leaves the fill window
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
         r_data  <= 5'd0;
      end else begin
         if ((r_state == ST_IDLE) && !seed_load && start) begin
            r_count <= '0;
         end
         if ((r_state == ST_GEN) && w_accept) begin
            r_data <= w_cand + 5'd1;
         end
         if ((r_state == ST_WRITE) && ready && !w_last) begin
            r_count <= r_count + c_CNT_W'(1);
         end
      end
   end

   assign addr = {{(32 - c_CNT_W){1'b0}}, r_count};
   assign data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_d20_roll_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d20_roll_loader
//  Purpose  : Self-checking bench for d20_roll_loader. A behavioural LFSR
//             model predicts every roll and the number of rejected draws
//             ahead of it; fills run with tied, stalled and random ready.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d20_roll_loader;

   localparam int          DEPTH = 32;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed = 16'd0;
   logic        ready = 1'b0;
   logic        write;
   logic [31:0] addr;
   logic [4:0]  data;
   logic        busy;
   logic        done;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] m_lfsr;
   int          seq_a   [DEPTH];
   int          seq_cur [DEPTH];

   always #5 clk = ~clk;

   d20_roll_loader #(
      .DEPTH        (DEPTH),
      .SEED_DEFAULT (SEED)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .seed_load (seed_load),
      .seed      (seed),
      .ready     (ready),
      .write     (write),
      .addr      (addr),
      .data      (data),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Draw the next accepted roll and how many draws were thrown away first
   task automatic model_next(output int val, output int rej);
      rej = -1;
      do begin
         m_lfsr = lfsr_step(m_lfsr);
         rej++;
      end while (m_lfsr[4:0] > 5'd19);
      val = int'(m_lfsr[4:0]) + 1;
   endtask

   task automatic drive_noise(input bit noise);
      if (noise) begin
         start     = 1'($urandom_range(0, 1));
         seed_load = 1'($urandom_range(0, 1));
         seed      = 16'($urandom);
      end
   endtask

   task automatic fill(input int pct, input bit noise, input int hold_beat,
                       input int abort_at, input bit done_start, output bit aborted);
      int beats;
      int gen_cnt;
      int cyc;
      int wcyc;
      int exp_val;
      int exp_rej;
      beats = 0; gen_cnt = 0; cyc = 0; wcyc = 0;
      aborted = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_next(exp_val, exp_rej);
      while (beats < DEPTH) begin
         if (cyc >= 4000) begin
            chk("fill_timeout", 32'd0, 32'd1);
            reset = 1'b0; start = 1'b0; seed_load = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            m_lfsr = SEED;
            return;
         end
         cyc++;
         if (write) begin
            if (wcyc == 0) chk("gen_cycles", gen_cnt, exp_rej + 1);
            chk("addr", addr, beats);
            chk("data", 32'(data), exp_val);
            chk("data_range", 32'((data >= 5'd1) && (data <= 5'd20)), 32'd1);
            chk("busy_write", 32'(busy), 32'd1);
            chk("done_write", 32'(done), 32'd0);
            if (beats == abort_at) begin
               reset = 1'b0; ready = 1'b0; start = 1'b0; seed_load = 1'b0;
               @(negedge clk);
               chk("rst_write", 32'(write), 32'd0);
               chk("rst_busy", 32'(busy), 32'd0);
               chk("rst_addr", addr, 32'd0);
               chk("rst_done", 32'(done), 32'd0);
               chk("rst_data", 32'(data), 32'd0);
               reset = 1'b1;
               m_lfsr = SEED;
               aborted = 1'b1;
               return;
            end
            gen_cnt = 0;
            if (beats == hold_beat && wcyc < 5) ready = 1'b0;
            else ready = ($urandom_range(0, 99) < pct);
            wcyc++;
            drive_noise(noise);
            @(negedge clk);
            if (ready) begin
               if (beats == hold_beat) chk("hold_write_cycles", wcyc, 32'd6);
               seq_cur[beats] = exp_val;
               beats++;
               wcyc = 0;
               if (beats < DEPTH) model_next(exp_val, exp_rej);
            end
         end else begin
            chk("busy_gen", 32'(busy), 32'd1);
            chk("done_gen", 32'(done), 32'd0);
            gen_cnt++;
            ready = 1'($urandom_range(0, 1));
            drive_noise(noise);
            @(negedge clk);
         end
      end
      start = 1'b0; seed_load = 1'b0; ready = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("write_done", 32'(write), 32'd0);
      if (done_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("write_idle", 32'(write), 32'd0);
      @(negedge clk);
      chk("busy_idle2", 32'(busy), 32'd0);
   endtask

   initial begin
      bit ab;
      int ndiff;
      logic [15:0] rseed;

      // Reset state
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_write", 32'(write), 32'd0);
      chk("reset_addr", addr, 32'd0);
      chk("reset_data", 32'(data), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      reset = 1'b1;
      m_lfsr = SEED;
      @(negedge clk);

      // Fill with ready tied high; keep as the reference reset sequence
      fill(100, 1'b0, -1, -1, 1'b0, ab);
      seq_a = seq_cur;

      // Back-to-back fill with a five-cycle stall on beat 3
      fill(100, 1'b0, 3, -1, 1'b0, ab);
      ndiff = 0;
      for (int i = 0; i < DEPTH; i++) if (seq_cur[i] != seq_a[i]) ndiff++;
      chk("fills_differ", 32'(ndiff != 0), 32'd1);

      // Random ready with start/seed_load/seed toggling during the fill
      fill(60, 1'b1, -1, -1, 1'b0, ab);

      // Zero seed reloads the default
      seed = 16'd0; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      chk("seed0_idle", 32'(busy), 32'd0);
      m_lfsr = SEED;
      fill(100, 1'b0, -1, -1, 1'b0, ab);
      ndiff = 0;
      for (int i = 0; i < DEPTH; i++) if (seq_cur[i] != seq_a[i]) ndiff++;
      chk("seed0_matches_reset", ndiff, 32'd0);

      // start together with seed_load: seed taken, no fill
      rseed = 16'($urandom_range(1, 65535));
      seed = rseed; start = 1'b1; seed_load = 1'b1;
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0;
      chk("both_no_fill", 32'(busy), 32'd0);
      @(negedge clk);
      chk("both_no_fill2", 32'(busy), 32'd0);
      m_lfsr = rseed;
      fill(70, 1'b1, -1, -1, 1'b0, ab);

      // Reset in the middle of a fill at beat 10
      fill(100, 1'b0, -1, 10, 1'b0, ab);
      chk("aborted", 32'(ab), 32'd1);

      // Restart after reset reproduces the reset sequence; start in DONE ignored
      fill(100, 1'b0, -1, -1, 1'b1, ab);
      ndiff = 0;
      for (int i = 0; i < DEPTH; i++) if (seq_cur[i] != seq_a[i]) ndiff++;
      chk("post_reset_matches", ndiff, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
